// File: rtl/rx_iq_packer.sv
// Receive-side I/Q packer: queues 24-bit I/Q pairs and writes each as three 16-bit words.
// Define RX_OVERFLOW_CNT_EN to build the saturating dropped-sample counter.
module rx_iq_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] rx_I,
  input  logic [23:0] rx_Q,
  input  logic        rx_strobe,
  input  logic        enable,
  output logic [15:0] fifo_data,
  output logic        fifo_wrreq,
  input  logic        fifo_full,
  input  logic        clear_ovf,
  output logic        overflow,
  output logic [15:0] overflow_cnt,
  output logic        busy
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

  state_e            state_q, state_d;
  logic [47:0]       mem_q [DEPTH];
  logic [47:0]       hold_q;
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              q_empty, q_full;
  logic              push, pop, drop;
  logic              overflow_q;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CntW'(DEPTH));
  // A pop in the same cycle never frees a slot for the incoming strobe.
  assign push    = rx_strobe & enable & ~q_full;
  assign drop    = rx_strobe & enable & q_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {rx_I, rx_Q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) hold_q <= mem_q[rd_ptr_q];
    end
  end

  // hold_q = {I, Q}; words are I[23:8], {I[7:0], Q[23:16]}, Q[15:0].
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    fifo_wrreq = 1'b0;
    fifo_data  = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = StW0;
        end
      end
      StW0: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = hold_q[47:32];
        if (!fifo_full) state_d = StW1;
      end
      StW1: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = hold_q[31:16];
        if (!fifo_full) state_d = StW2;
      end
      StW2: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = hold_q[15:0];
        if (!fifo_full) begin
          if (!q_empty) begin
            pop     = 1'b1;
            state_d = StW0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A drop in the same cycle as clear_ovf wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef RX_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q <= 16'h0000;
    end else if (drop) begin
      if (clear_ovf) begin
        ovf_cnt_q <= 16'h0001;
      end else if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_q <= ovf_cnt_q + 16'h0001;
      end
    end else if (clear_ovf) begin
      ovf_cnt_q <= 16'h0000;
    end
  end

  assign overflow_cnt = ovf_cnt_q;
`else
  assign overflow_cnt = 16'h0000;
`endif

  assign overflow = overflow_q;
  assign busy     = ~q_empty | (state_q != StIdle);

endmodule

// File: tb/tb_rx_iq_packer.sv
// Self-checking bench for rx_iq_packer: scoreboard of expected FIFO words, checked at each write.
module tb_rx_iq_packer;

`ifdef RX_OVERFLOW_CNT_EN
  localparam int CntScale = 1;
`else
  localparam int CntScale = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] rx_I, rx_Q;
  logic        rx_strobe, enable, fifo_full, clear_ovf;
  logic [15:0] fifo_data, overflow_cnt;
  logic        fifo_wrreq, overflow, busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] sb[$];
  int          wr_edges[$];

  rx_iq_packer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_I         (rx_I),
    .rx_Q         (rx_Q),
    .rx_strobe    (rx_strobe),
    .enable       (enable),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_full    (fifo_full),
    .clear_ovf    (clear_ovf),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: a word shown at this negedge is written on the next rising edge.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (reset && fifo_wrreq) begin
      n_tests++;
      if (fifo_full) begin
        n_fail++;
        $display("FAIL wrreq_while_full: wrreq=1 with fifo_full=1, required wrreq=0");
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", fifo_data);
      end else begin
        exp_w = sb.pop_front();
        if (fifo_data !== exp_w) begin
          n_fail++;
          $display("FAIL word: got %h, required %h", fifo_data, exp_w);
        end
      end
      wr_edges.push_back(cyc + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_pair(input logic [23:0] i, input logic [23:0] q);
    sb.push_back(i[23:8]);
    sb.push_back({i[7:0], q[23:16]});
    sb.push_back(q[15:0]);
  endfunction

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_I = '0; rx_Q = '0; rx_strobe = 0; enable = 1;
    fifo_full = 0; clear_ovf = 0;
    #12;
    n_tests++;
    if ({fifo_wrreq, fifo_data, overflow, overflow_cnt, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wrreq=%b data=%h ovf=%b cnt=%h busy=%b, required all 0",
               fifo_wrreq, fifo_data, overflow, overflow_cnt, busy);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int e;
    bit ok;
    wr_edges.delete();
    tick();
    e = cyc;
    rx_I = 24'h123456; rx_Q = 24'hABCDEF; rx_strobe = 1;
    push_pair(rx_I, rx_Q);
    tick();
    rx_strobe = 0;
    wait_idle(20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: timeout, required idle"); end
    n_tests++;
    if (wr_edges.size() != 3) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes, required 3", wr_edges.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (wr_edges[k] != e + 3 + k) begin
          n_fail++;
          $display("FAIL single_latency w%0d: got edge %0d, required %0d", k, wr_edges[k], e + 3 + k);
        end
      end
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b, required 0", overflow); end
  endtask

  task automatic test_stall();
    bit ok;
    wr_edges.delete();
    tick();
    rx_I = 24'h123456; rx_Q = 24'hABCDEF; rx_strobe = 1;
    push_pair(rx_I, rx_Q);
    tick();
    rx_strobe = 0;
    for (int k = 0; k < 10 && sb.size() != 2; k++) tick();
    fifo_full = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if (fifo_wrreq !== 1'b0 || fifo_data !== 16'h56AB) begin
        n_fail++;
        $display("FAIL stall_hold c%0d: got wrreq=%b data=%h, required wrreq=0 data=56ab",
                 k, fifo_wrreq, fifo_data);
      end
      tick();
    end
    fifo_full = 0;
    wait_idle(20, ok);
    n_tests++;
    if (!ok || wr_edges.size() != 3) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d writes ok=%b, required 3 ok=1", wr_edges.size(), ok);
    end else begin
      n_tests++;
      if (wr_edges[2] != wr_edges[1] + 1) begin
        n_fail++;
        $display("FAIL stall_resume: got W2 edge %0d, required %0d", wr_edges[2], wr_edges[1] + 1);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [23:0] i, q;
    wr_edges.delete();
    fifo_full = 1;
    tick();
    rx_I = 24'hA0A1A2; rx_Q = 24'hB0B1B2; rx_strobe = 1;
    push_pair(rx_I, rx_Q);
    tick();
    rx_strobe = 0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      i = 24'($urandom()); q = 24'($urandom());
      rx_I = i; rx_Q = q; rx_strobe = 1;
      if (k < 4) push_pair(i, q);
      tick();
    end
    rx_strobe = 0;
    n_tests++;
    if (overflow !== 1'b1 || overflow_cnt !== 16'(2 * CntScale)) begin
      n_fail++;
      $display("FAIL ovf_fill: got ovf=%b cnt=%0d, required ovf=1 cnt=%0d",
               overflow, overflow_cnt, 2 * CntScale);
    end
    n_tests++;
    if (busy !== 1'b1 || fifo_wrreq !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_blocked: got busy=%b wrreq=%b, required busy=1 wrreq=0", busy, fifo_wrreq);
    end
    rx_I = 24'h777777; rx_Q = 24'h888888; rx_strobe = 1; clear_ovf = 1;
    tick();
    rx_strobe = 0; clear_ovf = 0;
    n_tests++;
    if (overflow !== 1'b1 || overflow_cnt !== 16'(CntScale)) begin
      n_fail++;
      $display("FAIL clear_vs_drop: got ovf=%b cnt=%0d, required ovf=1 cnt=%0d",
               overflow, overflow_cnt, CntScale);
    end
    fifo_full = 0;
    wait_idle(60, ok);
    n_tests++;
    if (!ok || wr_edges.size() != 15) begin
      n_fail++;
      $display("FAIL ovf_drain: got %0d writes ok=%b, required 15 ok=1", wr_edges.size(), ok);
    end
    clear_ovf = 1;
    tick();
    clear_ovf = 0;
    n_tests++;
    if (overflow !== 1'b0 || overflow_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL clear: got ovf=%b cnt=%0d, required ovf=0 cnt=0", overflow, overflow_cnt);
    end
  endtask

  task automatic test_enable();
    bit ok;
    wr_edges.delete();
    enable = 0;
    for (int k = 0; k < 3; k++) begin
      rx_I = 24'($urandom()); rx_Q = 24'($urandom()); rx_strobe = 1;
      tick();
      rx_strobe = 0;
      tick();
    end
    repeat (6) tick();
    n_tests++;
    if (wr_edges.size() != 0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off: got writes=%0d ovf=%b busy=%b, required 0 0 0",
               wr_edges.size(), overflow, busy);
    end
    enable = 1; fifo_full = 1;
    for (int k = 0; k < 2; k++) begin
      rx_I = 24'($urandom()); rx_Q = 24'($urandom()); rx_strobe = 1;
      push_pair(rx_I, rx_Q);
      tick();
    end
    rx_strobe = 0; enable = 0;
    repeat (3) tick();
    fifo_full = 0;
    wait_idle(30, ok);
    n_tests++;
    if (!ok || wr_edges.size() != 6) begin
      n_fail++;
      $display("FAIL enable_drain: got %0d writes ok=%b, required 6 ok=1", wr_edges.size(), ok);
    end
    enable = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick();
    rx_I = 24'h0F1E2D; rx_Q = 24'h3C4B5A; rx_strobe = 1;
    push_pair(rx_I, rx_Q);
    tick();
    rx_strobe = 0;
    for (int k = 0; k < 10 && sb.size() != 2; k++) tick();
    reset = 0;
    #1;
    n_tests++;
    if ({fifo_wrreq, fifo_data, overflow, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got wrreq=%b data=%h ovf=%b busy=%b, required all 0",
               fifo_wrreq, fifo_data, overflow, busy);
    end
    sb.delete();
    wr_edges.delete();
    tick();
    reset = 1;
    tick();
    rx_I = 24'hC0FFEE; rx_Q = 24'hBADBED; rx_strobe = 1;
    push_pair(rx_I, rx_Q);
    tick();
    rx_strobe = 0;
    wait_idle(20, ok);
    n_tests++;
    if (!ok || wr_edges.size() != 3) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d writes ok=%b, required 3 ok=1", wr_edges.size(), ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wr_edges.delete();
    for (int k = 0; k < 100; k++) begin
      rx_I = 24'($urandom()); rx_Q = 24'($urandom()); rx_strobe = 1;
      push_pair(rx_I, rx_Q);
      tick();
      rx_strobe = 0;
      tick();
      tick();
    end
    wait_idle(20, ok);
    n_tests++;
    if (!ok || wr_edges.size() != 300) begin
      n_fail++;
      $display("FAIL stream_count: got %0d writes ok=%b, required 300 ok=1", wr_edges.size(), ok);
    end else begin
      n_tests++;
      if (wr_edges[299] - wr_edges[0] != 299) begin
        n_fail++;
        $display("FAIL stream_gapless: got span %0d, required 299", wr_edges[299] - wr_edges[0]);
      end
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_ovf: got %b, required 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_iq_packer.md
# rx_iq_packer

Receive-side sample packer: accepts decimated 24-bit I/Q sample pairs from the receiver chain, buffers them in a small sample queue and serialises each pair into three 16-bit words written into the rx FIFO via a write-request/full handshake. It is the writer counterpart of the transmitter's txFIFO reader: the downstream SPI/host interface drains the rx FIFO. Dropped samples are flagged, and optionally counted, so the host can detect stream gaps.

## Interface
- DEPTH, 4, sample-queue depth in I/Q pairs; power of two, 2..16
- clk  in  1  sample/system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_I  in  24  receiver I sample, two's complement
- rx_Q  in  24  receiver Q sample, two's complement
- rx_strobe  in  1  one-cycle pulse: rx_I/rx_Q valid this cycle
- enable  in  1  1 = accept new samples; 0 = ignore strobes
- fifo_data  out  16  word to rx FIFO
- fifo_wrreq  out  1  write request; word written on the edge where it is high
- fifo_full  in  1  rx FIFO full
- clear_ovf  in  1  one-cycle pulse: clear overflow status
- overflow  out  1  sticky: at least one sample dropped
- overflow_cnt  out  16  dropped-sample count (see Configuration)
- busy  out  1  queue non-empty or packer not IDLE

## Operation
- Word order per pair: W0 = I[23:8], W1 = {I[7:0], Q[23:16]}, W2 = Q[15:0] (byte stream I2 I1 I0 Q2 Q1 Q0).
- Push: rx_strobe & enable & count < DEPTH -> {I,Q} enqueued. No credit is given for a same-cycle pop: at count == DEPTH the strobe drops the sample even if a pop occurs.
- Drop: rx_strobe & enable & count == DEPTH -> sample discarded, overflow set, counter incremented.
- rx_strobe with enable = 0: ignored, no overflow, no count.
- Simultaneous push and pop: count unchanged; FIFO order is preserved.
- Packer FSM states: IDLE, W0, W1, W2.
  - IDLE: if the queue is non-empty, pop into the holding register -> W0.
  - Wk: fifo_wrreq = ~fifo_full. On a write, advance (W0->W1->W2). If fifo_full, hold the state; fifo_data stays stable.
  - W2 on write: if the queue is non-empty, pop -> W0 (back-to-back); else -> IDLE.
- fifo_wrreq and fifo_data are combinational from state, holding register and fifo_full. fifo_data = 0 in IDLE.
- A pair is never split: enable falling mid-pair, or with samples queued, still drains everything already accepted.
- clear_ovf clears overflow and overflow_cnt. If a drop occurs in the same cycle, the set wins: overflow = 1, cnt = 1.
- overflow_cnt saturates at 0xFFFF.

## Timing
- Reset (async assert, synchronous to clk on release): state IDLE, queue empty, fifo_wrreq 0, fifo_data 0, overflow 0, overflow_cnt 0, busy 0.
- Latency, empty queue, fifo_full low:
  - strobe sampled at edge N;
  - pop at edge N+1;
  - W0 written at edge N+2, W1 at N+3, W2 at N+4.
- Throughput: one word per cycle; sustained rate of one pair per 3 cycles with no drops when fifo_full stays low.
- Reset asserted mid-pair: the partial pair is discarded and queued samples are lost. The next accepted sample starts at W0; alignment is never resumed mid-pair.
- fifo_full is sampled every cycle; no write is issued while it is high.

## Configuration
- RX_OVERFLOW_CNT_EN defined: 16-bit saturating overflow_cnt implemented as described.
- Not defined: overflow_cnt is tied to 16'h0000. The overflow flag and all other behaviour are unchanged.

## Test plan
- Single pair I=0x123456, Q=0xABCDEF, fifo_full=0, strobe at edge N -> words 0x1234, 0x56AB, 0xCDEF written at edges N+2, N+3, N+4; overflow 0.
- fifo_full raised while in W1 for 10 cycles -> fifo_wrreq 0 and fifo_data held at 0x56AB throughout; on release, 0x56AB then 0xCDEF written on consecutive edges.
- DEPTH=4, fifo_full held high, 6 strobes -> only the first 4 pairs are queued (the pair held in the packer's holding register is additional), overflow=1, overflow_cnt=2 (0 without RX_OVERFLOW_CNT_EN); release -> all accepted pairs drained in order, 3 words each.
- enable=0 with 3 strobes -> no writes, overflow 0; enable dropped while 2 pairs are queued -> all 6 words still written.
- Reset asserted for one cycle right after W0 is written -> outputs return to reset values immediately; next strobe yields W0 of the new pair first.
- Strobes every 3 cycles for 100 pairs, fifo_full=0 -> 300 consecutive writes, overflow 0, clear_ovf concurrent with a drop leaves overflow=1, overflow_cnt=1.
